// File: rtl/seg_adder_pipe_if.sv
// Handshake and data bundle for seg_adder_pipe.
//   master: operand producer / result consumer side (drives IN_VALID, A, B,
//           CIN, SUB, OUT_READY; observes IN_READY, OUT_VALID, SUM, CO, OVF).
//   slave : the adder itself (the reverse directions).
interface seg_adder_pipe_if #(
    parameter int WIDTH = 64
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             SUB;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] SUM;
    logic             CO;
    logic             OVF;

    modport master (
        output IN_VALID, A, B, CIN, SUB, OUT_READY,
        input  IN_READY, OUT_VALID, SUM, CO, OVF
    );

    modport slave (
        input  IN_VALID, A, B, CIN, SUB, OUT_READY,
        output IN_READY, OUT_VALID, SUM, CO, OVF
    );
endinterface

// File: rtl/seg_adder_pipe.sv
// Multi-cycle segmented adder/subtractor.
// Adds one SEG_W-bit segment per clock with a registered inter-segment carry,
// so the critical path is a SEG_W-bit adder regardless of WIDTH.
// Ports:
//   CLK   - rising-edge clock
//   RST_N - asynchronous active-low reset
//   bus   - slave side of seg_adder_pipe_if:
//           IN_VALID/IN_READY handshake for A, B, CIN, SUB;
//           OUT_VALID/OUT_READY handshake for SUM, CO (not-borrow on SUB),
//           OVF (two's-complement overflow).
// Accept at edge t -> OUT_VALID after edge t+NSEG; one transaction in flight.
module seg_adder_pipe #(
    parameter int WIDTH = 64,
    parameter int SEG_W = 16
) (
    input logic           CLK,
    input logic           RST_N,
    seg_adder_pipe_if.slave bus
);
    localparam int unsigned NSEG  = WIDTH / SEG_W;
    localparam int          CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NSEG - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;       // already inverted for subtract
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               co_q;
    logic               ovf_q;

    logic [SEG_W-1:0]   seg_a;
    logic [SEG_W-1:0]   seg_b;
    logic [SEG_W:0]     seg_sum;
    logic               last_seg;
    logic               accept;

    assign bus.IN_READY  = (state_q == IDLE);
    assign bus.OUT_VALID = (state_q == DONE);
    assign bus.SUM       = sum_q;
    assign bus.CO        = co_q;
    assign bus.OVF       = ovf_q;

    assign accept   = (state_q == IDLE) && bus.IN_VALID;
    assign last_seg = (cnt_q == LAST_SEG);

    // Segment select by compare loop keeps every part-select constant-indexed.
    always_comb begin
        seg_a = '0;
        seg_b = '0;
        for (int unsigned i = 0; i < NSEG; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                seg_a = a_q[i*SEG_W +: SEG_W];
                seg_b = b_q[i*SEG_W +: SEG_W];
            end
        end
        seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.IN_VALID)  state_d = CALC;
            CALC:    if (last_seg)      state_d = DONE;
            DONE:    if (bus.OUT_READY) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.A;
                        b_q     <= bus.SUB ? ~bus.B : bus.B;
                        carry_q <= bus.SUB ? 1'b1 : bus.CIN;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    for (int unsigned i = 0; i < NSEG; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            sum_q[i*SEG_W +: SEG_W] <= seg_sum[SEG_W-1:0];
                        end
                    end
                    carry_q <= seg_sum[SEG_W];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_seg) begin
                        co_q  <= seg_sum[SEG_W];
                        // seg_sum[SEG_W-1] is the result MSB being written now.
                        ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (seg_sum[SEG_W-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
